// File: rtl/instr_mem_loader.sv
// Block loader for an instruction memory: streams words into consecutive addresses, then serves
// one-cycle-latency fetches. Optional macro INSTR_MEM_PARITY_EN adds an even-parity bit per word.
module instr_mem_loader #(
  parameter int ADDRESS_SIZE = 10,
  parameter int N            = 32   // must be a multiple of 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load_start,
  input  logic [ADDRESS_SIZE-1:0] load_base,
  input  logic [ADDRESS_SIZE:0]   load_count,
  input  logic                    load_valid,
  input  logic [N-1:0]            load_data,
  output logic                    load_ready,
  output logic                    load_busy,
  output logic                    load_done,
  input  logic                    fetch_en,
  input  logic [ADDRESS_SIZE-1:0] fetch_addr,
  output logic [N-1:0]            fetch_data,
  output logic                    fetch_valid,
  output logic                    parity_err,
  output logic [1:0]              dbg_state
);

  localparam int DEPTH = 2 ** ADDRESS_SIZE;
  localparam logic [ADDRESS_SIZE:0] DEPTH_CNT = {1'b1, {ADDRESS_SIZE{1'b0}}};

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]              state;
  logic [ADDRESS_SIZE-1:0] wr_ptr;
  logic [ADDRESS_SIZE:0]   remaining;
  logic [ADDRESS_SIZE:0]   count_clamped;
  logic                    xfer;
  logic                    fetch_hit;
  logic [N-1:0]            mem [DEPTH];

  // Handshake: a word moves when load_valid and load_ready are both high at a rising edge;
  // load_ready is high exactly while in LOAD and load_valid may be dropped at any time.
  assign load_ready = (state == ST_LOAD);
  assign load_busy  = (state == ST_LOAD);
  assign load_done  = (state == ST_DONE);
  assign dbg_state  = state;
  assign xfer       = load_valid && (state == ST_LOAD);
  assign fetch_hit  = fetch_en && (state != ST_LOAD);

  always_comb begin
    count_clamped = load_count;
    if (load_count > DEPTH_CNT) count_clamped = DEPTH_CNT;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      wr_ptr    <= '0;
      remaining <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (load_start) begin
            if (count_clamped != '0) begin
              state     <= ST_LOAD;
              wr_ptr    <= load_base;
              remaining <= count_clamped;
            end else begin
              state <= ST_DONE;
            end
          end
        end
        ST_LOAD: begin
          if (load_valid) begin
            wr_ptr    <= wr_ptr + 1'b1;
            remaining <= remaining - 1'b1;
            if (remaining == (ADDRESS_SIZE+1)'(1)) state <= ST_DONE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Storage is deliberately not reset; contents survive rst.
  always_ff @(posedge clk) begin
    if (xfer) mem[wr_ptr] <= load_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_valid <= 1'b0;
      fetch_data  <= '0;
    end else if (fetch_hit) begin
      fetch_valid <= 1'b1;
      fetch_data  <= mem[fetch_addr];
    end else begin
      fetch_valid <= 1'b0;
      fetch_data  <= '0;
    end
  end

`ifdef INSTR_MEM_PARITY_EN
  logic mem_par [DEPTH];

  always_ff @(posedge clk) begin
    if (xfer) mem_par[wr_ptr] <= ^load_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) parity_err <= 1'b0;
    else     parity_err <= fetch_hit && (mem_par[fetch_addr] != (^mem[fetch_addr]));
  end
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_instr_mem_loader.sv
// Self-checking bench for instr_mem_loader: table-driven fetch vectors, hand-written
// multi-cycle sequences, and a fetch scoreboard keyed on the expected output cycle.
module tb_instr_mem_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_start;
  logic [9:0]  load_base;
  logic [10:0] load_count;
  logic        load_valid;
  logic [31:0] load_data;
  logic        load_ready;
  logic        load_busy;
  logic        load_done;
  logic        fetch_en;
  logic [9:0]  fetch_addr;
  logic [31:0] fetch_data;
  logic        fetch_valid;
  logic        parity_err;
  logic [1:0]  dbg_state;

  instr_mem_loader #(.ADDRESS_SIZE(10), .N(32)) dut (
    .clk(clk), .rst(rst),
    .load_start(load_start), .load_base(load_base), .load_count(load_count),
    .load_valid(load_valid), .load_data(load_data),
    .load_ready(load_ready), .load_busy(load_busy), .load_done(load_done),
    .fetch_en(fetch_en), .fetch_addr(fetch_addr),
    .fetch_data(fetch_data), .fetch_valid(fetch_valid),
    .parity_err(parity_err), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;
  bit mon_on = 1'b0;

  logic [31:0] exp_q[$];
  int          due_q[$];
  bit          err_q[$];
  logic [31:0] word_q[$];
  logic [31:0] model_mem [1024];

  typedef struct {
    logic [9:0]  addr;
    logic [31:0] data;
  } fvec_t;
  fvec_t fvec [7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (mon_on) begin
      if (due_q.size() > 0 && due_q[0] == cyc) begin
        logic [31:0] d;
        bit          e;
        d = exp_q.pop_front();
        e = err_q.pop_front();
        void'(due_q.pop_front());
        chk("fetch_valid", {31'd0, fetch_valid}, 32'd1);
        chk("fetch_data", fetch_data, d);
        chk("parity_err", {31'd0, parity_err}, {31'd0, e});
      end else if (fetch_valid) begin
        chk("fetch_unexpected", {31'd0, fetch_valid}, 32'd0);
      end else begin
        chk("idle_fetch_data", fetch_data, 32'd0);
        chk("idle_parity_err", {31'd0, parity_err}, 32'd0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic fetch_req(input logic [9:0] a, input logic [31:0] d, input bit e);
    fetch_en   = 1'b1;
    fetch_addr = a;
    exp_q.push_back(d);
    due_q.push_back(cyc + 1);
    err_q.push_back(e);
    @(posedge clk); #1;
    fetch_en = 1'b0;
  endtask

  // Starts a load from IDLE and streams words; returns still in LOAD if max_xfer cuts it short.
  task automatic run_load(input logic [9:0] base, input logic [10:0] cnt, input bit gaps,
                          input int max_xfer);
    int          clamped, lim, xfers, cycles;
    logic [9:0]  ptr;
    bit          v;
    logic [31:0] d;
    clamped = (cnt > 11'd1024) ? 1024 : int'(cnt);
    lim     = (max_xfer < clamped) ? max_xfer : clamped;
    load_start = 1'b1;
    load_base  = base;
    load_count = cnt;
    @(posedge clk); #1;
    load_start = 1'b0;
    if (clamped == 0) begin
      chk("cnt0_done", {31'd0, load_done}, 32'd1);
      chk("cnt0_busy", {31'd0, load_busy}, 32'd0);
      chk("cnt0_ready", {31'd0, load_ready}, 32'd0);
      @(posedge clk); #1;
      chk("cnt0_done_clr", {31'd0, load_done}, 32'd0);
      chk("cnt0_busy_after", {31'd0, load_busy}, 32'd0);
      return;
    end
    ptr = base; xfers = 0; cycles = 0;
    while (xfers < lim && cycles < clamped * 4 + 16) begin
      chk("ld_busy", {31'd0, load_busy}, 32'd1);
      chk("ld_ready", {31'd0, load_ready}, 32'd1);
      v = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      d = $urandom();
      if (v && word_q.size() > 0) d = word_q.pop_front();
      load_valid = v;
      load_data  = d;
      @(posedge clk);
      if (v) begin
        model_mem[ptr] = d;
        ptr = ptr + 10'd1;
        xfers++;
      end
      cycles++;
      #1;
    end
    load_valid = 1'b0;
    if (xfers < lim) begin
      chk("ld_timeout", xfers, lim);
    end else if (lim == clamped) begin
      chk("ld_done_pulse", {31'd0, load_done}, 32'd1);
      chk("ld_done_busy", {31'd0, load_busy}, 32'd0);
      chk("ld_done_ready", {31'd0, load_ready}, 32'd0);
      @(posedge clk); #1;
      chk("ld_done_clr", {31'd0, load_done}, 32'd0);
      chk("ld_idle_state", {30'd0, dbg_state}, 32'd0);
    end
  endtask

  // ---------------- test ----------------
  initial begin
    fvec[0] = '{10'h010, 32'hA000_00A0};
    fvec[1] = '{10'h011, 32'hA111_00A1};
    fvec[2] = '{10'h012, 32'hA222_00A2};
    fvec[3] = '{10'h013, 32'hA333_00A3};
    fvec[4] = '{10'h3FE, 32'hB000_00B0};
    fvec[5] = '{10'h3FF, 32'hB111_00B1};
    fvec[6] = '{10'h000, 32'hB222_00B2};

    rst = 1'b1; load_start = 1'b0; load_base = '0; load_count = '0;
    load_valid = 1'b0; load_data = '0; fetch_en = 1'b0; fetch_addr = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", {31'd0, load_ready}, 32'd0);
    chk("rst_busy", {31'd0, load_busy}, 32'd0);
    chk("rst_done", {31'd0, load_done}, 32'd0);
    chk("rst_fvalid", {31'd0, fetch_valid}, 32'd0);
    chk("rst_fdata", fetch_data, 32'd0);
    chk("rst_perr", {31'd0, parity_err}, 32'd0);
    chk("rst_state", {30'd0, dbg_state}, 32'd0);
    rst = 1'b0;
    mon_on = 1'b1;
    @(posedge clk); #1;

    // Basic block of four and a wrapping block of three, continuous valid
    for (int i = 0; i < 4; i++) word_q.push_back(fvec[i].data);
    run_load(10'h010, 11'd4, 1'b0, 2000);
    for (int i = 4; i < 7; i++) word_q.push_back(fvec[i].data);
    run_load(10'h3FE, 11'd3, 1'b0, 2000);
    for (int i = 0; i < 7; i++) fetch_req(fvec[i].addr, fvec[i].data, 1'b0);

    // Back-pressure 1,0,0,1 with fetch held high; load_start in LOAD and DONE must be ignored
    load_start = 1'b1; load_base = 10'h100; load_count = 11'd2;
    @(posedge clk); #1;
    load_start = 1'b0;
    fetch_en = 1'b1; fetch_addr = 10'h010;
    for (int i = 0; i < 4; i++) begin
      bit v;
      v = (i == 0 || i == 3);
      chk("bp_busy", {31'd0, load_busy}, 32'd1);
      chk("bp_done_low", {31'd0, load_done}, 32'd0);
      load_valid = v;
      load_data  = (i == 0) ? 32'hC0C0_0C00 : 32'hC1C1_0C11;
      load_start = (i == 1);
      load_base  = 10'h300; load_count = 11'd5;
      @(posedge clk);
      if (v) model_mem[(i == 0) ? 10'h100 : 10'h101] = load_data;
      #1;
    end
    load_valid = 1'b0;
    chk("bp_done", {31'd0, load_done}, 32'd1);
    chk("bp_busy_done", {31'd0, load_busy}, 32'd0);
    chk("bp_ready_done", {31'd0, load_ready}, 32'd0);
    // Fetch issued in DONE sees the final written word; load_start here is ignored
    load_start = 1'b1;
    fetch_addr = 10'h101;
    exp_q.push_back(32'hC1C1_0C11); due_q.push_back(cyc + 1); err_q.push_back(1'b0);
    @(posedge clk); #1;
    load_start = 1'b0; fetch_en = 1'b0;
    chk("bp_idle_state", {30'd0, dbg_state}, 32'd0);
    chk("bp_idle_busy", {31'd0, load_busy}, 32'd0);
    fetch_req(10'h100, 32'hC0C0_0C00, 1'b0);

    // Zero count: immediate DONE, nothing written
    run_load(10'h010, 11'd0, 1'b0, 2000);
    fetch_req(10'h010, 32'hA000_00A0, 1'b0);

    // Oversized count clamps to a full-memory load, random valid gaps
    run_load(10'h000, 11'h7FF, 1'b1, 5000);
    for (int i = 0; i < 8; i++) begin
      logic [9:0] a;
      a = 10'($urandom_range(0, 1023));
      fetch_req(a, model_mem[a], 1'b0);
    end

    // Reset mid-load after 2 of 4 transfers
    run_load(10'h200, 11'd4, 1'b0, 2);
    rst = 1'b1;
    #1;
    chk("abort_ready", {31'd0, load_ready}, 32'd0);
    chk("abort_busy", {31'd0, load_busy}, 32'd0);
    chk("abort_done", {31'd0, load_done}, 32'd0);
    chk("abort_fvalid", {31'd0, fetch_valid}, 32'd0);
    chk("abort_fdata", fetch_data, 32'd0);
    chk("abort_state", {30'd0, dbg_state}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("abort_no_done", {31'd0, load_done}, 32'd0);
    end
    for (int i = 0; i < 4; i++) fetch_req(10'h200 + 10'(i), model_mem[10'h200 + 10'(i)], 1'b0);

`ifdef INSTR_MEM_PARITY_EN
    word_q.push_back(32'h0000_0001);
    run_load(10'h050, 11'd1, 1'b0, 2000);
    dut.mem_par[10'h050] = ~dut.mem_par[10'h050];
    fetch_req(10'h050, 32'h0000_0001, 1'b1);
`endif

    repeat (3) @(posedge clk);
    #1;
    chk("sb_drain", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
